usb_fs_line_rx: RTL and testbench

Full-speed USB receive front end for the bootloader. It takes the raw `usb_p_rx`/`usb_n_rx` pad inputs and recovers the 12 Mbit/s bit clock by 4x oversampling at `clk_48mhz`. It then performs NRZI decode, SYNC detection, bit unstuffing, byte assembly and EOP detection. Its output is a framed byte stream to the packet-level protocol engine, and it is suppressed while the device's own transmitter drives the bus.

---
 rtl/usb_fs_line_rx_pkg.sv | 62 ++++++
 rtl/usb_fs_line_rx_if.sv | 31 +++
 rtl/usb_fs_rx_dpll.sv | 81 ++++++++
 rtl/usb_fs_line_rx.sv | 198 +++++++++++++++++++
 tb/tb_usb_fs_line_rx.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_fs_line_rx_pkg.sv
// ---------------------------------------------------------------------------
// usb_fs_pkg
// Shared types and constants for the full-speed USB receive front end:
//   line_state_t - decoded D+/D- line state, encoded as {D+, D-}
//   rx_state_t   - receive FSM states
//   STUFF_LIMIT  - consecutive 1s after which a stuffed 0 must follow
//   SYNC_BYTE    - SYNC field as seen on the wire (LSB first)
//   ERR_*        - bit positions inside rx_pkt_err
// ---------------------------------------------------------------------------
package usb_fs_pkg;

    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_K   = 2'b01,
        LINE_J   = 2'b10,
        LINE_SE1 = 2'b11
    } line_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_SYNC,
        RX_DATA,
        RX_EOP,
        RX_ERR_WAIT
    } rx_state_t;

    localparam int unsigned STUFF_LIMIT = 6;
    localparam logic [7:0]  SYNC_BYTE   = 8'h80;

    localparam int unsigned ERR_STUFF   = 0;
    localparam int unsigned ERR_PARTIAL = 1;
    localparam int unsigned ERR_ABORT   = 2;

    typedef logic [2:0] rx_err_t;

    function automatic line_state_t decode_line(logic p, logic n);
        return line_state_t'({p, n});
    endfunction

    function automatic rx_err_t err_bit(int unsigned idx);
        rx_err_t e;
        e      = '0;
        e[idx] = 1'b1;
        return e;
    endfunction

    // Number of leading 0 bits on the wire before the SYNC-terminating 1.
    function automatic int unsigned sync_zero_bits(logic [7:0] pattern);
        int unsigned n;
        logic        found;
        n     = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (pattern[i])
                found = 1'b1;
            else if (!found)
                n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/usb_fs_line_rx_if.sv
// ---------------------------------------------------------------------------
// usb_fs_line_rx_if
// Framed byte stream from the line receiver to the protocol engine.
//   rx_active     - high from packet start through the packet-end cycle
//   rx_pkt_start  - one-cycle pulse on SYNC acceptance
//   rx_data       - received byte, qualified by rx_data_valid
//   rx_data_valid - one-cycle pulse per assembled byte
//   rx_pkt_end    - one-cycle pulse ending every started packet
//   rx_pkt_err    - error flags, qualified by rx_pkt_end
// master = receiver (drives), slave = consumer.
// ---------------------------------------------------------------------------
interface usb_fs_line_rx_if;
    import usb_fs_pkg::*;

    logic       rx_active;
    logic       rx_pkt_start;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_pkt_end;
    rx_err_t    rx_pkt_err;

    modport master (
        output rx_active, rx_pkt_start, rx_data, rx_data_valid,
               rx_pkt_end, rx_pkt_err
    );

    modport slave (
        input  rx_active, rx_pkt_start, rx_data, rx_data_valid,
               rx_pkt_end, rx_pkt_err
    );
endinterface

// File: rtl/usb_fs_rx_dpll.sv
// ---------------------------------------------------------------------------
// usb_fs_rx_dpll
// Pad synchronizer, line-state decode, oversampling bit recovery and NRZI
// decode.
//   clk_48mhz, reset       - clock, synchronous active-high reset
//   usb_p_rx, usb_n_rx     - asynchronous D+/D- pads
//   usb_tx_en              - local transmitter active: line forced to J
//   line_state             - synchronized line state
//   bit_strobe             - one cycle per bit, mid-bit
//   nrzi_bit               - decoded bit, valid with bit_strobe
// ---------------------------------------------------------------------------
module usb_fs_rx_dpll
    import usb_fs_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 4
) (
    input  logic        clk_48mhz,
    input  logic        reset,
    input  logic        usb_p_rx,
    input  logic        usb_n_rx,
    input  logic        usb_tx_en,
    output line_state_t line_state,
    output logic        bit_strobe,
    output logic        nrzi_bit
);
    localparam int unsigned     PW           = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0]   STROBE_PHASE = PW'(OVERSAMPLE / 2);

    logic [1:0]    p_sync;
    logic [1:0]    n_sync;
    logic [PW-1:0] phase;
    line_state_t   prev_state;
    logic          line_change;

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            p_sync <= 2'b11;
            n_sync <= 2'b00;
        end else begin
            p_sync <= {p_sync[0], usb_p_rx};
            n_sync <= {n_sync[0], usb_n_rx};
        end
    end

    always_comb begin
        line_state = LINE_J;
        if (!usb_tx_en)
            line_state = decode_line(p_sync[1], n_sync[1]);
    end

    // The change is detected between the two synchronizer stages, so phase
    // is already 0 in the first cycle the new state appears on line_state;
    // the strobe then lands in the third cycle of each bit.
    always_comb begin
        line_change = 1'b0;
        if (!usb_tx_en)
            line_change = decode_line(p_sync[0], n_sync[0]) !=
                          decode_line(p_sync[1], n_sync[1]);
    end

    assign bit_strobe = (phase == STROBE_PHASE);
    assign nrzi_bit   = (line_state == prev_state);

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            phase      <= '0;
            prev_state <= LINE_J;
        end else begin
            if (line_change)
                phase <= '0;
            else
                phase <= phase + 1'b1;

            if (usb_tx_en)
                prev_state <= LINE_J;
            else if (bit_strobe)
                prev_state <= line_state;
        end
    end

endmodule

// File: rtl/usb_fs_line_rx.sv
// ---------------------------------------------------------------------------
// usb_fs_line_rx
// Full-speed USB receive front end: recovers bits from the raw pads and
// delivers a framed byte stream (SYNC detect, unstuffing, byte assembly,
// EOP detect). Receive is suppressed while the local transmitter is active.
//   clk_48mhz, reset       - 48 MHz clock, synchronous active-high reset
//   usb_p_rx, usb_n_rx     - asynchronous D+/D- pads
//   usb_tx_en              - local transmitter active (aborts receive)
//   rx_bus (master)        - framed byte stream and packet flags
// ---------------------------------------------------------------------------
module usb_fs_line_rx
    import usb_fs_pkg::*;
#(
    parameter int unsigned OVERSAMPLE       = 4,
    parameter int unsigned MIN_SYNC_ZEROS   = 5,
    parameter int unsigned EOP_TIMEOUT_BITS = 3
) (
    input  logic                    clk_48mhz,
    input  logic                    reset,
    input  logic                    usb_p_rx,
    input  logic                    usb_n_rx,
    input  logic                    usb_tx_en,
    usb_fs_line_rx_if.master        rx_bus
);
    localparam logic [2:0]        MIN_ZEROS = 3'(MIN_SYNC_ZEROS);
    localparam logic [2:0]        ZERO_SAT  = 3'(sync_zero_bits(SYNC_BYTE));
    localparam logic [2:0]        STUFF_MAX = 3'(STUFF_LIMIT);
    localparam int unsigned       EW        = $clog2(EOP_TIMEOUT_BITS + 1);
    localparam logic [EW-1:0]     EOP_LAST  = EW'(EOP_TIMEOUT_BITS - 1);

    line_state_t line_state;
    logic        bit_strobe;
    logic        nrzi_bit;

    rx_state_t   state;
    logic [2:0]  zero_cnt;
    logic [2:0]  ones_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic [EW-1:0] eop_cnt;
    logic        se0_seen;

    logic        active_q;
    logic        start_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        end_q;
    rx_err_t     err_q;

    usb_fs_rx_dpll #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_dpll (
        .clk_48mhz  (clk_48mhz),
        .reset      (reset),
        .usb_p_rx   (usb_p_rx),
        .usb_n_rx   (usb_n_rx),
        .usb_tx_en  (usb_tx_en),
        .line_state (line_state),
        .bit_strobe (bit_strobe),
        .nrzi_bit   (nrzi_bit)
    );

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state     <= RX_IDLE;
            zero_cnt  <= '0;
            ones_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            eop_cnt   <= '0;
            se0_seen  <= 1'b0;
            active_q  <= 1'b0;
            start_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            end_q     <= 1'b0;
            err_q     <= '0;
        end else begin
            start_q <= 1'b0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            if (end_q)
                active_q <= 1'b0;

            if (usb_tx_en) begin
                // Own transmission: a started packet is closed immediately.
                if (state == RX_DATA || state == RX_EOP) begin
                    end_q <= 1'b1;
                    err_q <= err_bit(ERR_ABORT);
                end
                state <= RX_IDLE;
            end else if (bit_strobe) begin
                case (state)
                    RX_IDLE: begin
                        if (line_state == LINE_K) begin
                            state    <= RX_SYNC;
                            zero_cnt <= 3'd1;
                        end
                    end

                    RX_SYNC: begin
                        if (line_state == LINE_SE0 || line_state == LINE_SE1) begin
                            state <= RX_IDLE;
                        end else if (!nrzi_bit) begin
                            if (zero_cnt != ZERO_SAT)
                                zero_cnt <= zero_cnt + 3'd1;
                        end else if (zero_cnt >= MIN_ZEROS) begin
                            state    <= RX_DATA;
                            start_q  <= 1'b1;
                            active_q <= 1'b1;
                            err_q    <= '0;
                            bit_cnt  <= '0;
                            ones_cnt <= '0;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end

                    RX_DATA: begin
                        if (line_state == LINE_SE0) begin
                            state   <= RX_EOP;
                            eop_cnt <= '0;
                        end else if (line_state == LINE_SE1) begin
                            end_q    <= 1'b1;
                            err_q    <= err_bit(ERR_ABORT);
                            se0_seen <= 1'b0;
                            state    <= RX_ERR_WAIT;
                        end else if (ones_cnt == STUFF_MAX) begin
                            if (nrzi_bit) begin
                                end_q    <= 1'b1;
                                err_q    <= err_bit(ERR_STUFF);
                                se0_seen <= 1'b0;
                                state    <= RX_ERR_WAIT;
                            end else begin
                                ones_cnt <= '0;
                            end
                        end else begin
                            ones_cnt  <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                            shift_reg <= {nrzi_bit, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                data_q  <= {nrzi_bit, shift_reg[7:1]};
                                valid_q <= 1'b1;
                            end
                        end
                    end

                    RX_EOP: begin
                        case (line_state)
                            LINE_J: begin
                                end_q <= 1'b1;
                                err_q <= (bit_cnt != 3'd0) ? err_bit(ERR_PARTIAL) : '0;
                                state <= RX_IDLE;
                            end
                            LINE_SE0: begin
                                if (eop_cnt == EOP_LAST) begin
                                    end_q    <= 1'b1;
                                    err_q    <= err_bit(ERR_ABORT);
                                    se0_seen <= 1'b1;
                                    state    <= RX_ERR_WAIT;
                                end else begin
                                    eop_cnt <= eop_cnt + 1'b1;
                                end
                            end
                            default: begin
                                end_q    <= 1'b1;
                                err_q    <= err_bit(ERR_ABORT);
                                se0_seen <= 1'b0;
                                state    <= RX_ERR_WAIT;
                            end
                        endcase
                    end

                    RX_ERR_WAIT: begin
                        case (line_state)
                            LINE_SE0: se0_seen <= 1'b1;
                            LINE_J: begin
                                if (se0_seen)
                                    state <= RX_IDLE;
                            end
                            default:  se0_seen <= 1'b0;
                        endcase
                    end

                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    assign rx_bus.rx_active     = active_q;
    assign rx_bus.rx_pkt_start  = start_q;
    assign rx_bus.rx_data       = data_q;
    assign rx_bus.rx_data_valid = valid_q;
    assign rx_bus.rx_pkt_end    = end_q;
    assign rx_bus.rx_pkt_err    = err_q;

endmodule

// File: tb/tb_usb_fs_line_rx.sv
// ---------------------------------------------------------------------------
// tb_usb_fs_line_rx
// Host-side model encodes packets (SYNC, stuffing, NRZI, EOP) onto the pads;
// a monitor collects the framed output, which is compared against the
// packet contents the host intended to send.
// ---------------------------------------------------------------------------
module tb_usb_fs_line_rx;

    logic clk_48mhz = 1'b0;
    logic reset;
    logic usb_p_rx;
    logic usb_n_rx;
    logic usb_tx_en;

    always #5 clk_48mhz = ~clk_48mhz;

    usb_fs_line_rx_if rx_bus ();

    usb_fs_line_rx #(
        .OVERSAMPLE       (4),
        .MIN_SYNC_ZEROS   (5),
        .EOP_TIMEOUT_BITS (3)
    ) dut (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .usb_p_rx  (usb_p_rx),
        .usb_n_rx  (usb_n_rx),
        .usb_tx_en (usb_tx_en),
        .rx_bus    (rx_bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- monitor ----------------
    int unsigned obs_starts;
    logic [7:0]  obs_bytes[$];
    logic [2:0]  obs_ends[$];
    int unsigned act_bad     = 0;
    int unsigned overlap_bad = 0;
    bit          in_pkt      = 1'b0;

    always @(posedge clk_48mhz) begin
        #1;
        if (reset) begin
            in_pkt = 1'b0;
        end else begin
            if (rx_bus.rx_active !== (rx_bus.rx_pkt_start || in_pkt))
                act_bad++;
            if (rx_bus.rx_data_valid && rx_bus.rx_pkt_end)
                overlap_bad++;
            if (rx_bus.rx_data_valid && !in_pkt)
                overlap_bad++;
            if (rx_bus.rx_pkt_start) begin
                obs_starts++;
                in_pkt = 1'b1;
            end
            if (rx_bus.rx_data_valid)
                obs_bytes.push_back(rx_bus.rx_data);
            if (rx_bus.rx_pkt_end) begin
                obs_ends.push_back(rx_bus.rx_pkt_err);
                in_pkt = 1'b0;
            end
        end
    end

    // ---------------- host model ----------------
    bit          bits_q[$];
    int unsigned ones_run;
    int unsigned width_idx;
    bit          alt_mode;

    int unsigned exp_starts;
    logic [7:0]  exp_bytes[$];
    logic [2:0]  exp_ends[$];

    task automatic add_sync(int unsigned zeros);
        repeat (zeros) bits_q.push_back(1'b0);
        bits_q.push_back(1'b1);
        ones_run = 0;
    endtask

    task automatic add_byte(logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            bits_q.push_back(b[i]);
            if (b[i]) ones_run++;
            else      ones_run = 0;
            if (ones_run == 6) begin
                bits_q.push_back(1'b0);
                ones_run = 0;
            end
        end
    endtask

    task automatic add_raw(bit b);
        bits_q.push_back(b);
    endtask

    function automatic int unsigned next_width();
        if (!alt_mode) return 4;
        width_idx++;
        return (width_idx % 2) ? 3 : 5;
    endfunction

    task automatic drive_line(logic p, logic n, int unsigned cycles);
        usb_p_rx = p;
        usb_n_rx = n;
        repeat (cycles) @(negedge clk_48mhz);
    endtask

    task automatic play(bit with_eop);
        logic lvl_j;
        lvl_j = 1'b1;
        foreach (bits_q[i]) begin
            if (!bits_q[i]) lvl_j = !lvl_j;
            drive_line(lvl_j, !lvl_j, next_width());
        end
        bits_q.delete();
        if (with_eop) begin
            drive_line(1'b0, 1'b0, next_width());
            drive_line(1'b0, 1'b0, next_width());
            drive_line(1'b1, 1'b0, next_width());
        end
    endtask

    task automatic idle(int unsigned cycles);
        drive_line(1'b1, 1'b0, cycles);
    endtask

    task automatic clear_all();
        obs_starts = 0;
        obs_bytes.delete();
        obs_ends.delete();
        exp_starts = 0;
        exp_bytes.delete();
        exp_ends.delete();
        width_idx = 0;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare(string tag);
        check($sformatf("%s.starts", tag), obs_starts, exp_starts);
        check($sformatf("%s.nbytes", tag), obs_bytes.size(), exp_bytes.size());
        for (int i = 0; i < obs_bytes.size() && i < exp_bytes.size(); i++)
            check($sformatf("%s.byte%0d", tag, i), obs_bytes[i], exp_bytes[i]);
        check($sformatf("%s.nends", tag), obs_ends.size(), exp_ends.size());
        for (int i = 0; i < obs_ends.size() && i < exp_ends.size(); i++)
            check($sformatf("%s.err%0d", tag, i), obs_ends[i], exp_ends[i]);
        check($sformatf("%s.active_window", tag), act_bad, 0);
        check($sformatf("%s.valid_end_overlap", tag), overlap_bad, 0);
    endtask

    task automatic check_outputs_zero(string tag);
        check($sformatf("%s.active", tag), rx_bus.rx_active, 0);
        check($sformatf("%s.start", tag), rx_bus.rx_pkt_start, 0);
        check($sformatf("%s.data", tag), rx_bus.rx_data, 0);
        check($sformatf("%s.valid", tag), rx_bus.rx_data_valid, 0);
        check($sformatf("%s.end", tag), rx_bus.rx_pkt_end, 0);
        check($sformatf("%s.err", tag), rx_bus.rx_pkt_err, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int unsigned nb;

        reset     = 1'b1;
        usb_tx_en = 1'b0;
        usb_p_rx  = 1'b1;
        usb_n_rx  = 1'b0;
        alt_mode  = 1'b0;
        clear_all();
        repeat (3) @(negedge clk_48mhz);
        check_outputs_zero("reset");
        reset = 1'b0;
        idle(20);

        // Basic two-byte packet
        clear_all();
        add_sync(7); add_byte(8'hC3); add_byte(8'hA5);
        play(1'b1); idle(40);
        exp_starts = 1; exp_bytes = '{8'hC3, 8'hA5}; exp_ends = '{3'b000};
        compare("basic");

        // Bit stuffing in both bytes
        clear_all();
        add_sync(7); add_byte(8'hFF); add_byte(8'h7E);
        play(1'b1); idle(40);
        exp_starts = 1; exp_bytes = '{8'hFF, 8'h7E}; exp_ends = '{3'b000};
        compare("stuffed");

        // Missing stuff bit, then a packet-shaped burst that must be ignored
        // until the bus goes SE0 -> J
        clear_all();
        add_sync(7);
        repeat (7) add_raw(1'b1);
        add_sync(7); add_byte(8'h55);
        play(1'b1); idle(40);
        exp_starts = 1; exp_ends = '{3'b001};
        compare("stuff_err");

        // Partial byte at EOP
        clear_all();
        add_sync(7); add_byte(8'h2D);
        add_raw(1'b1); add_raw(1'b0); add_raw(1'b1);
        play(1'b1); idle(40);
        exp_starts = 1; exp_bytes = '{8'h2D}; exp_ends = '{3'b010};
        compare("partial");

        // Short SYNC (3 and 4 zeros) rejected, exactly 5 zeros accepted
        clear_all();
        add_sync(3); play(1'b0); idle(40);
        add_sync(4); play(1'b0); idle(40);
        compare("short_sync");
        clear_all();
        add_sync(5); add_byte(8'h5A);
        play(1'b1); idle(40);
        exp_starts = 1; exp_bytes = '{8'h5A}; exp_ends = '{3'b000};
        compare("min_sync");

        // Bit widths alternating 3/5 cycles
        clear_all();
        alt_mode = 1'b1;
        add_sync(7); add_byte(8'h96); add_byte(8'h0F); add_byte(8'hFC);
        play(1'b1); alt_mode = 1'b0; idle(40);
        exp_starts = 1; exp_bytes = '{8'h96, 8'h0F, 8'hFC}; exp_ends = '{3'b000};
        compare("jitter");

        // Random payloads
        for (int k = 0; k < 4; k++) begin
            clear_all();
            alt_mode = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 4);
            add_sync(7);
            for (int j = 0; j < int'(nb); j++) begin
                b = 8'($urandom);
                add_byte(b);
                exp_bytes.push_back(b);
            end
            play(1'b1); alt_mode = 1'b0; idle(40);
            exp_starts = 1; exp_ends = '{3'b000};
            compare($sformatf("random%0d", k));
        end

        // Local transmitter takes the bus after the first byte
        clear_all();
        add_sync(7); add_byte(8'hE1);
        add_raw(1'b1); add_raw(1'b0); add_raw(1'b1); add_raw(1'b1);
        play(1'b0);
        repeat (2) @(negedge clk_48mhz);
        usb_tx_en = 1'b1;
        @(posedge clk_48mhz); #1;
        check("txen.end", rx_bus.rx_pkt_end, 1);
        check("txen.err", rx_bus.rx_pkt_err, 3'b100);
        @(negedge clk_48mhz);
        add_sync(7); add_byte(8'h99);
        play(1'b1); idle(20);
        usb_tx_en = 1'b0;
        idle(40);
        exp_starts = 1; exp_bytes = '{8'hE1}; exp_ends = '{3'b100};
        compare("txen");

        // Reset in the middle of a byte
        clear_all();
        add_sync(7);
        add_raw(1'b1); add_raw(1'b0); add_raw(1'b1);
        play(1'b0);
        check("rst.active_before", rx_bus.rx_active, 1);
        reset    = 1'b1;
        usb_p_rx = 1'b1;
        usb_n_rx = 1'b0;
        @(posedge clk_48mhz); #1;
        check_outputs_zero("midrst");
        @(negedge clk_48mhz);
        reset = 1'b0;
        idle(40);
        exp_starts = 1;
        compare("midrst_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
